// File: rtl/fuel_dispense_ctrl.sv
// Fuel dispenser transaction controller: drives the fuel counter's start/stop,
// stops it exactly on the preset volume and reports dispensed volume and cost.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_IDLE       | no transaction, waiting for a preset
// S_ARMED      | preset latched, waiting for nozzle lift + trigger
// S_DISPENSING | counter enabled, watching target / nozzle / trigger
// S_PAUSED     | trigger released, counter held, pause timer running
// S_DONE       | transaction closed, results frozen until the next preset
module fuel_dispense_ctrl #(
    parameter int VOL_W         = 8,
    parameter int PRICE_W       = 8,
    parameter int COST_W        = 16,
    parameter int PAUSE_TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               preset_valid,
    input  logic [VOL_W-1:0]   preset_volume,
    input  logic [PRICE_W-1:0] unit_price,
    input  logic               nozzle_lift,
    input  logic               trigger,
    input  logic [VOL_W-1:0]   fuel_amount,
    output logic               start,
    output logic               stop,
    output logic               busy,
    output logic               done,
    output logic               preset_err,
    output logic [VOL_W-1:0]   dispensed,
    output logic [COST_W-1:0]  cost
);

    localparam int TMR_W = (PAUSE_TIMEOUT > 1) ? $clog2(PAUSE_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PAUSE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DISPENSING,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [VOL_W-1:0]   base_q, preset_q, vol_diff;
    logic [PRICE_W-1:0] price_q;
    logic [TMR_W-1:0]   timer_q;
    logic               preset_ok;
    logic               latch_preset, latch_base, clear_result, track_result;
    logic               timer_clr, timer_inc;
    logic               start_nxt, stop_nxt, err_nxt, busy_nxt, done_nxt;

    // Modular difference keeps a counter wrap inside a transaction invisible.
    assign vol_diff  = fuel_amount - base_q;
    assign preset_ok = preset_valid && (preset_volume != '0);

    always_comb begin
        state_nxt    = state;
        latch_preset = 1'b0;
        latch_base   = 1'b0;
        clear_result = 1'b0;
        err_nxt      = 1'b0;
        timer_clr    = 1'b0;
        timer_inc    = 1'b0;

        unique case (state)
            S_IDLE, S_DONE: begin
                if (preset_valid) begin
                    if (preset_ok) begin
                        latch_preset = 1'b1;
                        clear_result = 1'b1;
                        state_nxt    = S_ARMED;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (preset_valid) begin
                    latch_preset = preset_ok;
                    err_nxt      = !preset_ok;
                end
                if (nozzle_lift && trigger) begin
                    latch_base = 1'b1;
                    state_nxt  = S_DISPENSING;
                end
            end
            S_DISPENSING: begin
                // Stop is raised one count early: the counter still takes this edge.
                if (vol_diff == preset_q - VOL_W'(1)) begin
                    state_nxt = S_DONE;
                end else if (!nozzle_lift) begin
                    state_nxt = S_DONE;
                end else if (!trigger) begin
                    state_nxt = S_PAUSED;
                    timer_clr = 1'b1;
                end
            end
            S_PAUSED: begin
                if (!nozzle_lift) begin
                    state_nxt = S_DONE;
                end else if (trigger) begin
                    state_nxt = S_DISPENSING;
                    timer_clr = 1'b1;
                end else if (timer_q == TMR_LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start_nxt = 1'b0;
        stop_nxt  = 1'b0;
        unique case (state_nxt)
            S_DISPENSING: start_nxt = 1'b1;
            S_PAUSED: begin
                start_nxt = 1'b1;
                stop_nxt  = 1'b1;
            end
            S_DONE: begin
                start_nxt = (state == S_DISPENSING);
                stop_nxt  = (state == S_DISPENSING);
            end
            default: ;
        endcase
        busy_nxt = (state_nxt == S_ARMED) || (state_nxt == S_DISPENSING) ||
                   (state_nxt == S_PAUSED);
        done_nxt = (state_nxt == S_DONE) && (state != S_DONE);
    end

    // The first DONE cycle still tracks, catching the count taken on the stop edge.
    assign track_result = (state == S_DISPENSING) || (state == S_PAUSED) ||
                          ((state == S_DONE) && done);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            start      <= 1'b0;
            stop       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            preset_err <= 1'b0;
            dispensed  <= '0;
            cost       <= '0;
            base_q     <= '0;
            preset_q   <= '0;
            price_q    <= '0;
            timer_q    <= '0;
        end else begin
            state      <= state_nxt;
            start      <= start_nxt;
            stop       <= stop_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            preset_err <= err_nxt;
            if (latch_preset) begin
                preset_q <= preset_volume;
                price_q  <= unit_price;
            end
            if (latch_base) begin
                base_q <= fuel_amount;
            end
            if (timer_clr) begin
                timer_q <= '0;
            end else if (timer_inc) begin
                timer_q <= timer_q + TMR_W'(1);
            end
            if (clear_result) begin
                dispensed <= '0;
                cost      <= '0;
            end else if (track_result) begin
                dispensed <= vol_diff;
                cost      <= COST_W'(vol_diff) * COST_W'(price_q);
            end
        end
    end

endmodule

// File: tb/tb_fuel_dispense_ctrl.sv
// Directed bench for fuel_dispense_ctrl with a behavioural fuel counter per DUT;
// instance b uses a short pause timeout for the timeout scenario.
module tb_fuel_dispense_ctrl;

    logic       clk = 1'b0;
    logic       reset, preset_valid, nozzle_lift, trigger, load_en;
    logic [7:0] preset_volume, unit_price, load_val;
    logic [7:0] fa_a, fa_b;

    logic        start_a, stop_a, busy_a, done_a, preset_err_a;
    logic [7:0]  dispensed_a;
    logic [15:0] cost_a;
    logic        start_b, stop_b, busy_b, done_b, preset_err_b;
    logic [7:0]  dispensed_b;
    logic [15:0] cost_b;

    int n_tests = 0;
    int n_fail  = 0;
    int n;

    always #5 clk = ~clk;

    fuel_dispense_ctrl #(.VOL_W(8), .PRICE_W(8), .COST_W(16), .PAUSE_TIMEOUT(1000)) dut_a (
        .clk(clk), .reset(reset), .preset_valid(preset_valid), .preset_volume(preset_volume),
        .unit_price(unit_price), .nozzle_lift(nozzle_lift), .trigger(trigger),
        .fuel_amount(fa_a), .start(start_a), .stop(stop_a), .busy(busy_a), .done(done_a),
        .preset_err(preset_err_a), .dispensed(dispensed_a), .cost(cost_a)
    );

    fuel_dispense_ctrl #(.VOL_W(8), .PRICE_W(8), .COST_W(16), .PAUSE_TIMEOUT(16)) dut_b (
        .clk(clk), .reset(reset), .preset_valid(preset_valid), .preset_volume(preset_volume),
        .unit_price(unit_price), .nozzle_lift(nozzle_lift), .trigger(trigger),
        .fuel_amount(fa_b), .start(start_b), .stop(stop_b), .busy(busy_b), .done(done_b),
        .preset_err(preset_err_b), .dispensed(dispensed_b), .cost(cost_b)
    );

    // Fuel counter: counts on edges that see start=1, stop=0.
    always @(posedge clk) begin
        if (load_en) fa_a <= load_val;
        else if (start_a && !stop_a) fa_a <= fa_a + 8'd1;
    end
    always @(posedge clk) begin
        if (load_en) fa_b <= load_val;
        else if (start_b && !stop_b) fa_b <= fa_b + 8'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] v);
        load_val = v;
        load_en  = 1'b1;
        step();
        load_en  = 1'b0;
    endtask

    task automatic arm(input logic [7:0] p, input logic [7:0] pr);
        preset_valid  = 1'b1;
        preset_volume = p;
        unit_price    = pr;
        step();
        preset_valid  = 1'b0;
    endtask

    task automatic wait_done(input bit use_b, output int cnt);
        cnt = 0;
        while (((use_b ? done_b : done_a) == 1'b0) && cnt < 300) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        reset = 1'b0; preset_valid = 1'b0; preset_volume = '0; unit_price = '0;
        nozzle_lift = 1'b0; trigger = 1'b0; load_en = 1'b1; load_val = 8'h10;

        // 1: reset state, then preset 5 at price 3 from base 0x10
        steps(2);
        load_en = 1'b0;
        chk("rst_start", 32'(start_a), 0);
        chk("rst_stop", 32'(stop_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_err", 32'(preset_err_a), 0);
        chk("rst_disp", 32'(dispensed_a), 0);
        chk("rst_cost", 32'(cost_a), 0);
        reset = 1'b1;
        arm(8'd5, 8'd3);
        chk("t1_armed_busy", 32'(busy_a), 1);
        chk("t1_armed_start", 32'(start_a), 0);
        nozzle_lift = 1'b1; trigger = 1'b1;
        step();
        chk("t1_run_start", 32'(start_a), 1);
        chk("t1_run_stop", 32'(stop_a), 0);
        chk("t1_base_fa", 32'(fa_a), 32'h10);
        wait_done(1'b0, n);
        chk("t1_cycles", 32'(n), 5);
        chk("t1_stopedge_start", 32'(start_a), 1);
        chk("t1_stopedge_stop", 32'(stop_a), 1);
        chk("t1_fa_final", 32'(fa_a), 32'h15);
        step();
        chk("t1_disp", 32'(dispensed_a), 5);
        chk("t1_cost", 32'(cost_a), 15);
        chk("t1_done_pulse_off", 32'(done_a), 0);
        chk("t1_busy_off", 32'(busy_a), 0);
        chk("t1_start_off", 32'(start_a), 0);
        steps(3);
        chk("t1_fa_hold", 32'(fa_a), 32'h15);
        chk("t1_disp_frozen", 32'(dispensed_a), 5);
        nozzle_lift = 1'b0; trigger = 1'b0;

        // 2: counter wrap, base 0xFC, preset 10 at price 7
        load(8'hFC);
        arm(8'd10, 8'd7);
        chk("t2_clear_disp", 32'(dispensed_a), 0);
        chk("t2_clear_cost", 32'(cost_a), 0);
        nozzle_lift = 1'b1; trigger = 1'b1;
        step();
        wait_done(1'b0, n);
        chk("t2_cycles", 32'(n), 10);
        chk("t2_fa_wrap", 32'(fa_a), 32'h06);
        step();
        chk("t2_disp", 32'(dispensed_a), 10);
        chk("t2_cost", 32'(cost_a), 70);
        step();
        chk("t2_no_overshoot", 32'(fa_a), 32'h06);
        nozzle_lift = 1'b0; trigger = 1'b0;

        // 3: preset 20, pause after 7 counts for 30 cycles, resume; preset ignored mid-run
        load(8'h00);
        arm(8'd20, 8'd2);
        nozzle_lift = 1'b1; trigger = 1'b1;
        step();
        steps(3);
        preset_valid = 1'b1; preset_volume = 8'd2;
        step();
        preset_valid = 1'b0;
        chk("t3_ignore_err", 32'(preset_err_a), 0);
        steps(3);
        chk("t3_fa7", 32'(fa_a), 7);
        trigger = 1'b0;
        step();
        chk("t3_pause_start", 32'(start_a), 1);
        chk("t3_pause_stop", 32'(stop_a), 1);
        chk("t3_extra_count", 32'(fa_a), 8);
        chk("t3_disp_lag", 32'(dispensed_a), 7);
        steps(30);
        chk("t3_fa_frozen", 32'(fa_a), 8);
        chk("t3_stop_held", 32'(stop_a), 1);
        chk("t3_busy_held", 32'(busy_a), 1);
        chk("t3_disp_pause", 32'(dispensed_a), 8);
        chk("t3_no_done", 32'(done_a), 0);
        trigger = 1'b1;
        step();
        chk("t3_resume_stop", 32'(stop_a), 0);
        chk("t3_resume_start", 32'(start_a), 1);
        wait_done(1'b0, n);
        chk("t3_cycles", 32'(n), 12);
        chk("t3_fa_final", 32'(fa_a), 20);
        step();
        chk("t3_disp", 32'(dispensed_a), 20);
        chk("t3_cost", 32'(cost_a), 40);
        nozzle_lift = 1'b0; trigger = 1'b0;

        // 4: pause timeout on dut_b (16 cycles), then hang-up mid-dispense
        load(8'h30);
        arm(8'd50, 8'd1);
        nozzle_lift = 1'b1; trigger = 1'b1;
        step();
        steps(3);
        trigger = 1'b0;
        step();
        chk("t4_pause_stop", 32'(stop_b), 1);
        chk("t4_pause_fa", 32'(fa_b), 32'h34);
        wait_done(1'b1, n);
        chk("t4_timeout_cycles", 32'(n), 16);
        chk("t4_busy_off", 32'(busy_b), 0);
        step();
        chk("t4_disp", 32'(dispensed_b), 4);
        chk("t4_cost", 32'(cost_b), 4);
        chk("t4_fa_hold", 32'(fa_b), 32'h34);
        nozzle_lift = 1'b0;
        step();
        load(8'h00);
        arm(8'd50, 8'd2);
        nozzle_lift = 1'b1; trigger = 1'b1;
        step();
        steps(6);
        nozzle_lift = 1'b0;
        step();
        chk("t4_hang_done", 32'(done_b), 1);
        chk("t4_hang_stop", 32'(stop_b), 1);
        chk("t4_hang_fa", 32'(fa_b), 7);
        step();
        chk("t4_hang_disp", 32'(dispensed_b), 7);
        chk("t4_hang_cost", 32'(cost_b), 14);
        chk("t4_hang_start_off", 32'(start_b), 0);
        trigger = 1'b0;

        // 5: zero preset rejected (IDLE and ARMED), preset 1 delivers one count
        reset = 1'b0;
        step();
        reset = 1'b1;
        preset_valid = 1'b1; preset_volume = 8'd0; unit_price = 8'd9;
        step();
        preset_valid = 1'b0;
        chk("t5_err_pulse", 32'(preset_err_a), 1);
        chk("t5_err_idle", 32'(busy_a), 0);
        step();
        chk("t5_err_clear", 32'(preset_err_a), 0);
        chk("t5_still_idle", 32'(busy_a), 0);
        arm(8'd3, 8'd9);
        chk("t5_armed", 32'(busy_a), 1);
        arm(8'd0, 8'd9);
        chk("t5_armed_err", 32'(preset_err_a), 1);
        chk("t5_armed_stays", 32'(busy_a), 1);
        arm(8'd1, 8'd9);
        load(8'h80);
        nozzle_lift = 1'b1; trigger = 1'b1;
        step();
        chk("t5_one_start", 32'(start_a), 1);
        chk("t5_one_fa0", 32'(fa_a), 32'h80);
        step();
        chk("t5_one_done", 32'(done_a), 1);
        chk("t5_one_stop", 32'(stop_a), 1);
        chk("t5_one_fa1", 32'(fa_a), 32'h81);
        step();
        chk("t5_one_fa_hold", 32'(fa_a), 32'h81);
        chk("t5_one_disp", 32'(dispensed_a), 1);
        chk("t5_one_cost", 32'(cost_a), 9);
        nozzle_lift = 1'b0; trigger = 1'b0;

        // 6: reset mid-dispense at dispensed=3
        load(8'h00);
        arm(8'd50, 8'd4);
        nozzle_lift = 1'b1; trigger = 1'b1;
        step();
        steps(4);
        chk("t6_disp3", 32'(dispensed_a), 3);
        chk("t6_cost12", 32'(cost_a), 12);
        reset = 1'b0;
        step();
        chk("t6_rst_start", 32'(start_a), 0);
        chk("t6_rst_stop", 32'(stop_a), 0);
        chk("t6_rst_disp", 32'(dispensed_a), 0);
        chk("t6_rst_cost", 32'(cost_a), 0);
        chk("t6_rst_busy", 32'(busy_a), 0);
        chk("t6_rst_done", 32'(done_a), 0);
        reset = 1'b1;
        step();
        chk("t6_after_done", 32'(done_a), 0);
        chk("t6_after_start", 32'(start_a), 0);
        chk("t6_after_fa", 32'(fa_a), 5);
        nozzle_lift = 1'b0; trigger = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
